multi_timer: RTL
================

# multi_timer

Parametrised multi-channel down-counting timer with a register interface, one-shot/periodic modes, per-channel interrupt enables and a sticky write-1-to-clear interrupt status. Each channel counts LOAD cycles and then flags expiry. Expiry flags combine into a per-channel vector and one OR-reduced interrupt line. It sits on the local register bus as a drop-in timer peripheral and replaces single-channel, fixed-width timers.

## Interface
- NUM_CH, 4, number of independent timer channels; 1..min(32, DATA_W)
- CNT_W, 16, counter and LOAD width; CNT_W <= DATA_W
- DATA_W, 16, register bus data width
- ADDR_W, 8, register bus address width; >= 8
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- addr  input  ADDR_W  register address
- wr  input  1  write strobe, one cycle per write
- rd  input  1  read strobe, one cycle per read
- wdata  input  DATA_W  write data
- rdata  output  DATA_W  read data, registered
- rvalid  output  1  rdata valid, one-cycle pulse
- intr_vec  output  NUM_CH  per-channel interrupt: status & irq_en
- intr  output  1  OR of intr_vec

## Operation
- Register map. The channel c base address is 4*c.
  - +0 CTRL (RW): bit0 EN, bit1 PERIODIC, bit2 IRQ_EN; other bits read 0.
  - +1 LOAD (RW): CNT_W bits.
  - +2 COUNT (RO): live counter.
  - +3 reserved.
- Global registers:
  - 0x80 INT_STATUS: sticky expiry bits, write-1-to-clear; writing 0 has no effect.
  - 0x81 INT_PENDING (RO): INT_STATUS & IRQ_EN vector.
- Unmapped or out-of-range addresses (channel >= NUM_CH) read 0 and ignore writes.
- Writes to RO registers are ignored. wdata bits above the register width are ignored; reads are zero-extended.
- Per-channel FSM, states IDLE and RUN:
  - IDLE: if EN=1 and LOAD!=0, then COUNT<=LOAD and go to RUN. Otherwise stay in IDLE. EN=1 with LOAD=0 waits in IDLE with EN held at 1.
  - RUN, EN=0: abort to IDLE. COUNT holds its value, no status set.
  - RUN, COUNT>1: COUNT<=COUNT-1.
  - RUN, COUNT==1: expiry. Set INT_STATUS[c].
    - PERIODIC=1 and LOAD!=0: COUNT<=LOAD, stay in RUN.
    - Otherwise: COUNT<=0, hardware clears EN, go to IDLE.
- LOAD writes during RUN do not disturb COUNT; they take effect at the next reload.
- PERIODIC and IRQ_EN writes during RUN take effect immediately.
- Simultaneous expiry and W1C of the same INT_STATUS bit: the set wins.
- Simultaneous software write of EN=1 and hardware auto-clear of EN: the software write wins.
- wr and rd in the same cycle are both performed. A read returns pre-write register contents.

## Timing
- Reset values:
  - All CTRL, LOAD, COUNT and INT_STATUS are 0.
  - All FSMs are in IDLE.
  - rdata=0, rvalid=0, intr_vec=0, intr=0.
- Reset is asynchronous and may occur mid-count. All channels abort immediately and no interrupt is generated.
- Read latency is 1 cycle. Strobe rd at edge T gives rdata and rvalid valid after edge T, for one cycle. rdata holds its value when rvalid=0.
- Start latency:
  - A CTRL write with EN=1 at edge T enters RUN at edge T+1 with COUNT=LOAD.
  - INT_STATUS[c] sets at edge T+LOAD+1.
  - intr_vec and intr follow in the same cycle. They are combinational from flops with no extra delay.
- Periodic period is exactly LOAD cycles between successive INT_STATUS set events.
- A W1C at edge T drops intr_vec after edge T.
- Channels are fully independent. Several channels may expire on the same edge.

## Test plan
- Reset then read every register -> all read 0, rvalid a single pulse per rd, intr=0.
- Ch0 one-shot: LOAD=5, CTRL=0x5 at edge T -> INT_STATUS[0] and intr rise at T+6, CTRL reads 0x4 (EN auto-cleared), COUNT=0.
- Ch1 periodic: LOAD=3, CTRL=0x7 -> INT_STATUS[1] sets every 3 cycles. W1C 0x2 coinciding with an expiry -> bit stays 1.
- Abort and reset mid-count:
  - Ch2 LOAD=10 running, write CTRL=0 at count 4 -> IDLE, COUNT reads 4, no status.
  - Repeat with rst_n low mid-count -> all registers 0.
- IRQ masking: ch3 expires with IRQ_EN=0 -> INT_STATUS[3]=1, INT_PENDING=0, intr=0. Set IRQ_EN -> intr=1 next cycle.
- Boundaries:
  - EN=1 with LOAD=0 -> stays IDLE, no status.
  - LOAD=0xFFFF (CNT_W=16) -> expiry at T+65536.
  - Write LOAD=0 during periodic run -> stops after the current period, EN cleared.

Source files
------------

// File: rtl/multi_timer.sv
// Multi-channel down-counting timer peripheral: per-channel one-shot/periodic
// counters behind a small register map, with sticky W1C status and masked interrupts.
module multi_timer #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr,
  input  logic              rd,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic [NUM_CH-1:0] intr_vec,
  output logic              intr
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state    [NUM_CH];
  state_t             state_nx [NUM_CH];
  logic [CNT_W-1:0]   load     [NUM_CH];
  logic [CNT_W-1:0]   load_nx  [NUM_CH];
  logic [CNT_W-1:0]   count    [NUM_CH];
  logic [CNT_W-1:0]   count_nx [NUM_CH];
  logic [NUM_CH-1:0]  en, en_nx, per, per_nx, irq_en, irq_nx;
  logic [NUM_CH-1:0]  status, status_nx, expire;

  logic [ADDR_W-3:0]  ch_idx;
  logic [1:0]         reg_sel;
  logic               is_ch, is_stat, is_pend;
  logic [DATA_W-1:0]  rd_val;

  assign ch_idx  = addr[ADDR_W-1:2];
  assign reg_sel = addr[1:0];
  assign is_ch   = (ch_idx < (ADDR_W-2)'(NUM_CH));
  assign is_stat = (addr == ADDR_W'(8'h80));
  assign is_pend = (addr == ADDR_W'(8'h81));

  assign intr_vec = status & irq_en;
  assign intr     = |intr_vec;

  always_comb begin
    expire = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      state_nx[c] = state[c];
      count_nx[c] = count[c];
      load_nx[c]  = load[c];
      en_nx[c]    = en[c];
      per_nx[c]   = per[c];
      irq_nx[c]   = irq_en[c];

      case (state[c])
        IDLE: begin
          if (en[c] && load[c] != '0) begin
            count_nx[c] = load[c];
            state_nx[c] = RUN;
          end
        end
        RUN: begin
          if (!en[c]) begin
            state_nx[c] = IDLE;
          end else if (count[c] > CNT_W'(1)) begin
            count_nx[c] = count[c] - CNT_W'(1);
          end else begin
            expire[c] = 1'b1;
            if (per[c] && load[c] != '0) begin
              count_nx[c] = load[c];
            end else begin
              count_nx[c] = '0;
              en_nx[c]    = 1'b0;
              state_nx[c] = IDLE;
            end
          end
        end
        default: state_nx[c] = IDLE;
      endcase

      // Software CTRL write is applied last so it overrides the hardware EN clear.
      if (wr && is_ch && ch_idx == (ADDR_W-2)'(c)) begin
        if (reg_sel == 2'd0) begin
          en_nx[c]  = wdata[0];
          per_nx[c] = wdata[1];
          irq_nx[c] = wdata[2];
        end else if (reg_sel == 2'd1) begin
          load_nx[c] = wdata[CNT_W-1:0];
        end
      end
    end

    status_nx = status;
    if (wr && is_stat)
      status_nx = status_nx & ~wdata[NUM_CH-1:0];
    status_nx = status_nx | expire;
  end

  always_comb begin
    rd_val = '0;
    if (is_ch) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (ch_idx == (ADDR_W-2)'(c)) begin
          case (reg_sel)
            2'd0:    rd_val = DATA_W'({irq_en[c], per[c], en[c]});
            2'd1:    rd_val = DATA_W'(load[c]);
            2'd2:    rd_val = DATA_W'(count[c]);
            default: rd_val = '0;
          endcase
        end
      end
    end else if (is_stat) begin
      rd_val = DATA_W'(status);
    end else if (is_pend) begin
      rd_val = DATA_W'(intr_vec);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        state[c] <= IDLE;
        count[c] <= '0;
        load[c]  <= '0;
      end
      en     <= '0;
      per    <= '0;
      irq_en <= '0;
      status <= '0;
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        state[c] <= state_nx[c];
        count[c] <= count_nx[c];
        load[c]  <= load_nx[c];
      end
      en     <= en_nx;
      per    <= per_nx;
      irq_en <= irq_nx;
      status <= status_nx;
      rvalid <= rd;
      if (rd)
        rdata <= rd_val;
    end
  end

endmodule
